wb_handshake_stage: RTL and testbench

- Write-back stage of the GALS CPU. Sits between the ALU (upstream) and the register file (downstream), on its own clock domain.
- Accepts ALU results over a 4-phase bundled-data req/ack handshake and buffers them in a small FIFO.
- Drains the FIFO into the register file over a second 4-phase req/ack handshake. Both incoming handshake inputs are synchronised locally.

---
 rtl/wb_handshake_stage_if.sv | 29 ++
 rtl/wb_handshake_stage.sv | 172 +++++++++++++++++
 tb/tb_wb_handshake_stage.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_handshake_stage_if.sv
// Handshake bundle for the write-back stage.
//   ALU side : req, ack, alu_result, alu_dest, alu_wen  (4-phase bundled data)
//   RF side  : rf_req, rf_ack, write_reg, write_addr, write_data  (4-phase)
// master is the environment view (ALU + register file), slave is the stage view.
interface wb_handshake_stage_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              req;
    logic              ack;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] alu_dest;
    logic              alu_wen;
    logic              rf_req;
    logic              rf_ack;
    logic              write_reg;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;

    modport master (
        output req, alu_result, alu_dest, alu_wen, rf_ack,
        input  ack, rf_req, write_reg, write_addr, write_data
    );

    modport slave (
        input  req, alu_result, alu_dest, alu_wen, rf_ack,
        output ack, rf_req, write_reg, write_addr, write_data
    );
endinterface

// File: rtl/wb_handshake_stage.sv
// Write-back stage: accepts ALU results over a 4-phase req/ack handshake, buffers
// them in a small FIFO and drains them into the register file over a second
// 4-phase handshake. Results with wen=0 retire without an RF transaction.
// Ports:
//   clk, reset     stage clock, synchronous active-high reset
//   bus (slave)    ALU and register-file handshake signals
//   occupancy      FIFO entries held (includes the entry being written to the RF)
//   retired_count  instructions retired, wraps at 16 bits
module wb_handshake_stage #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    wb_handshake_stage_if.slave        bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [15:0]                retired_count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = 1 + ADDR_W + DATA_W;

    typedef enum logic {InIdle, InAck} in_state_e;
    typedef enum logic [1:0] {OutIdle, OutReq, OutRelease} out_state_e;

    // Synchronisers for the asynchronous handshake inputs.
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic [SYNC_STAGES-1:0] rf_ack_sync_q;
    logic                   req_s;
    logic                   rf_ack_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_sync_q    <= '0;
            rf_ack_sync_q <= '0;
        end else begin
            req_sync_q    <= {req_sync_q[SYNC_STAGES-2:0], bus.req};
            rf_ack_sync_q <= {rf_ack_sync_q[SYNC_STAGES-2:0], bus.rf_ack};
        end
    end

    assign req_s    = req_sync_q[SYNC_STAGES-1];
    assign rf_ack_s = rf_ack_sync_q[SYNC_STAGES-1];

    // FIFO storage; entry layout is {wen, dest, data}.
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop, load;
    logic             full;
    logic [ENT_W-1:0] head;
    logic             head_wen;
    logic [ADDR_W-1:0] head_dest;
    logic [DATA_W-1:0] head_data;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign head      = mem_q[rd_ptr_q];
    assign head_wen  = head[ENT_W-1];
    assign head_dest = head[DATA_W +: ADDR_W];
    assign head_data = head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.alu_wen, bus.alu_dest, bus.alu_result};
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Input FSM.
    in_state_e in_state_q, in_state_d;

    always_comb begin
        in_state_d = in_state_q;
        push       = 1'b0;
        case (in_state_q)
            InIdle: begin
                if (req_s && !full) begin
                    push       = 1'b1;
                    in_state_d = InAck;
                end
            end
            InAck: begin
                if (!req_s) begin
                    in_state_d = InIdle;
                end
            end
            default: in_state_d = InIdle;
        endcase
    end

    // Output FSM. The head stays in the FIFO until the RF acknowledges it.
    out_state_e        out_state_q, out_state_d;
    logic [ADDR_W-1:0] write_addr_q;
    logic [DATA_W-1:0] write_data_q;
    logic [15:0]       retired_count_q;

    always_comb begin
        out_state_d = out_state_q;
        pop         = 1'b0;
        load        = 1'b0;
        case (out_state_q)
            OutIdle: begin
                if (count_q != '0) begin
                    if (!head_wen) begin
                        pop = 1'b1;
                    end else begin
                        load        = 1'b1;
                        out_state_d = OutReq;
                    end
                end
            end
            OutReq: begin
                if (rf_ack_s) begin
                    pop         = 1'b1;
                    out_state_d = OutRelease;
                end
            end
            OutRelease: begin
                if (!rf_ack_s) begin
                    out_state_d = OutIdle;
                end
            end
            default: out_state_d = OutIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_state_q      <= InIdle;
            out_state_q     <= OutIdle;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            write_addr_q    <= '0;
            write_data_q    <= '0;
            retired_count_q <= '0;
        end else begin
            in_state_q      <= in_state_d;
            out_state_q     <= out_state_d;
            count_q         <= count_d;
            retired_count_q <= retired_count_q + 16'(pop);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (load) begin
                write_addr_q <= head_dest;
                write_data_q <= head_data;
            end
        end
    end

    assign bus.ack        = (in_state_q == InAck);
    assign bus.rf_req     = (out_state_q == OutReq);
    assign bus.write_reg  = (out_state_q == OutReq);
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign occupancy      = count_q;
    assign retired_count  = retired_count_q;
endmodule

// File: tb/tb_wb_handshake_stage.sv
// Self-checking bench for wb_handshake_stage: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// queue-based reference model.
module tb_wb_handshake_stage;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned DEPTH       = 2;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [CNT_W-1:0] occupancy;
    logic [15:0]      retired_count;

    wb_handshake_stage_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    wb_handshake_stage #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus_if),
        .occupancy     (occupancy),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- Reference model ----------------
    typedef struct packed {
        logic              wen;
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t                   mq[$];
    bit [SYNC_STAGES-1:0]   m_req_hist;
    bit [SYNC_STAGES-1:0]   m_ack_hist;
    bit                     m_ack, m_rf_req, m_release;
    logic [ADDR_W-1:0]      m_wa;
    logic [DATA_W-1:0]      m_wd;
    logic [15:0]            m_retired;
    bit                     model_valid = 1'b0;

    always @(posedge clk) begin : model
        bit   rs, ras, do_pop;
        int   size_pre;
        ent_t e;
        if (reset) begin
            mq.delete();
            m_req_hist  = '0;
            m_ack_hist  = '0;
            m_ack       = 1'b0;
            m_rf_req    = 1'b0;
            m_release   = 1'b0;
            m_wa        = '0;
            m_wd        = '0;
            m_retired   = '0;
            model_valid = 1'b1;
        end else begin
            // The stage only sees each handshake input SYNC_STAGES edges late.
            rs         = m_req_hist[SYNC_STAGES-1];
            ras        = m_ack_hist[SYNC_STAGES-1];
            m_req_hist = {m_req_hist[SYNC_STAGES-2:0], bus_if.req};
            m_ack_hist = {m_ack_hist[SYNC_STAGES-2:0], bus_if.rf_ack};
            size_pre   = mq.size();
            do_pop     = 1'b0;
            if (m_rf_req) begin
                if (ras) begin
                    m_rf_req  = 1'b0;
                    m_release = 1'b1;
                    do_pop    = 1'b1;
                end
            end else if (m_release) begin
                if (!ras) m_release = 1'b0;
            end else if (size_pre > 0) begin
                if (!mq[0].wen) begin
                    do_pop = 1'b1;
                end else begin
                    m_wa     = mq[0].dest;
                    m_wd     = mq[0].data;
                    m_rf_req = 1'b1;
                end
            end
            if (do_pop) begin
                void'(mq.pop_front());
                m_retired = m_retired + 16'd1;
            end
            if (!m_ack) begin
                if (rs && size_pre < DEPTH) begin
                    e.wen  = bus_if.alu_wen;
                    e.dest = bus_if.alu_dest;
                    e.data = bus_if.alu_result;
                    mq.push_back(e);
                    m_ack = 1'b1;
                end
            end else if (!rs) begin
                m_ack = 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            check_val("cyc_ack", bus_if.ack, m_ack);
            check_val("cyc_rf_req", bus_if.rf_req, m_rf_req);
            check_val("cyc_write_reg", bus_if.write_reg, m_rf_req);
            check_val("cyc_write_addr", bus_if.write_addr, m_wa);
            check_val("cyc_write_data", bus_if.write_data, m_wd);
            check_val("cyc_occupancy", occupancy, mq.size());
            check_val("cyc_retired", retired_count, m_retired);
        end
    end

    // ---------------- RF side: responder and write log ----------------
    bit                rf_auto   = 1'b0;
    logic              rf_manual = 1'b0;
    logic              prev_rf_req = 1'b0;
    int                rf_rises = 0;
    logic [ADDR_W-1:0] log_addr[$];
    logic [DATA_W-1:0] log_data[$];

    always @(negedge clk) begin
        if (rf_auto) begin
            if (bus_if.rf_ack !== 1'b1 && bus_if.rf_req === 1'b1 && ($urandom % 2) == 1)
                bus_if.rf_ack = 1'b1;
            else if (bus_if.rf_ack === 1'b1 && bus_if.rf_req === 1'b0 && ($urandom % 2) == 1)
                bus_if.rf_ack = 1'b0;
        end else begin
            bus_if.rf_ack = rf_manual;
        end
    end

    always @(negedge clk) begin
        if (bus_if.rf_req === 1'b1 && prev_rf_req !== 1'b1) begin
            rf_rises++;
            log_addr.push_back(bus_if.write_addr);
            log_data.push_back(bus_if.write_data);
        end
        prev_rf_req = bus_if.rf_req;
    end

    // ---------------- Helpers ----------------
    task automatic wait_ack(input logic val, input string name);
        int n = 0;
        while (bus_if.ack !== val && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val(name, bus_if.ack, val);
    endtask

    task automatic wait_rf_req(input logic val, input string name);
        int n = 0;
        while (bus_if.rf_req !== val && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val(name, bus_if.rf_req, val);
    endtask

    task automatic wait_drained(input string name);
        int n = 0;
        while ((occupancy !== '0 || bus_if.rf_req !== 1'b0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val(name, occupancy, 0);
    endtask

    task automatic alu_send(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                            input logic w);
        @(negedge clk);
        bus_if.alu_result = d;
        bus_if.alu_dest   = a;
        bus_if.alu_wen    = w;
        bus_if.req        = 1'b1;
        wait_ack(1'b1, "alu_ack_rise");
        bus_if.req = 1'b0;
        wait_ack(1'b0, "alu_ack_fall");
    endtask

    // Scenario 2 body: literal latency and data expectations.
    task automatic single_write(input logic [15:0] exp_retired);
        rf_auto   = 1'b0;
        rf_manual = 1'b0;
        @(negedge clk);
        bus_if.alu_result = 16'h1234;
        bus_if.alu_dest   = 4'd5;
        bus_if.alu_wen    = 1'b1;
        bus_if.req        = 1'b1;
        @(negedge clk);
        check_val("sw_ack_edge1", bus_if.ack, 0);
        @(negedge clk);
        check_val("sw_ack_edge2", bus_if.ack, 0);
        @(negedge clk);
        check_val("sw_ack_edge3", bus_if.ack, 1);
        @(negedge clk);
        check_val("sw_rf_req", bus_if.rf_req, 1);
        check_val("sw_write_reg", bus_if.write_reg, 1);
        check_val("sw_write_addr", bus_if.write_addr, 5);
        check_val("sw_write_data", bus_if.write_data, 16'h1234);
        bus_if.req = 1'b0;
        rf_manual  = 1'b1;
        wait_rf_req(1'b0, "sw_rf_req_fall");
        rf_manual = 1'b0;
        repeat (6) @(negedge clk);
        check_val("sw_retired", retired_count, exp_retired);
        check_val("sw_occupancy", occupancy, 0);
        check_val("sw_ack_idle", bus_if.ack, 0);
    endtask

    // ---------------- Stimulus ----------------
    initial begin : stim
        bit                seen;
        int                log_start;
        int                rises0;
        logic [ADDR_W-1:0] exp_addr[$];
        logic [DATA_W-1:0] exp_data[$];
        logic [DATA_W-1:0] d;
        logic [ADDR_W-1:0] a;
        logic              w;
        int                nrand;

        reset             = 1'b1;
        bus_if.req        = 1'b0;
        bus_if.alu_result = '0;
        bus_if.alu_dest   = '0;
        bus_if.alu_wen    = 1'b0;

        // 1. Reset with random inputs.
        repeat (3) begin
            @(negedge clk);
            bus_if.req        = 1'($urandom);
            bus_if.alu_result = 16'($urandom);
            bus_if.alu_dest   = 4'($urandom);
            bus_if.alu_wen    = 1'($urandom);
        end
        @(negedge clk);
        check_val("rst_ack", bus_if.ack, 0);
        check_val("rst_rf_req", bus_if.rf_req, 0);
        check_val("rst_write_reg", bus_if.write_reg, 0);
        check_val("rst_write_addr", bus_if.write_addr, 0);
        check_val("rst_write_data", bus_if.write_data, 0);
        check_val("rst_occupancy", occupancy, 0);
        check_val("rst_retired", retired_count, 0);
        bus_if.req = 1'b0;
        reset      = 1'b0;
        repeat (2) @(negedge clk);

        // 2. Single write.
        single_write(16'd1);

        // 3. Retire without write.
        rises0 = rf_rises;
        alu_send(16'hBEEF, 4'd7, 1'b0);
        repeat (6) @(negedge clk);
        check_val("nw_no_rf_req", rf_rises, rises0);
        check_val("nw_retired", retired_count, 2);

        // 4. Backpressure.
        rf_auto   = 1'b0;
        rf_manual = 1'b0;
        log_start = log_addr.size();
        alu_send(16'h0001, 4'd1, 1'b1);
        alu_send(16'h0002, 4'd2, 1'b1);
        repeat (2) @(negedge clk);
        check_val("bp_occupancy_full", occupancy, 2);
        @(negedge clk);
        bus_if.alu_result = 16'h0003;
        bus_if.alu_dest   = 4'd3;
        bus_if.alu_wen    = 1'b1;
        bus_if.req        = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus_if.ack !== 1'b0) seen = 1'b1;
        end
        check_val("bp_third_blocked", seen, 0);
        rf_manual = 1'b1;
        wait_rf_req(1'b0, "bp_rf_req_fall");
        rf_manual = 1'b0;
        wait_ack(1'b1, "bp_third_acked");
        bus_if.req = 1'b0;
        wait_ack(1'b0, "bp_third_ack_fall");
        rf_auto = 1'b1;
        wait_drained("bp_drained");
        rf_auto = 1'b0;
        repeat (6) @(negedge clk);
        check_val("bp_log_count", log_addr.size() - log_start, 3);
        for (int i = 0; i < 3; i++) begin
            if (log_start + i < log_addr.size()) begin
                check_val("bp_order_addr", log_addr[log_start+i], i + 1);
                check_val("bp_order_data", log_data[log_start+i], i + 1);
            end
        end
        check_val("bp_retired", retired_count, 5);

        // 5. Reset mid-transfer.
        rf_auto   = 1'b0;
        rf_manual = 1'b0;
        repeat (2) @(negedge clk);
        alu_send(16'h00A1, 4'd8, 1'b1);
        alu_send(16'h00A2, 4'd9, 1'b1);
        repeat (2) @(negedge clk);
        check_val("mr_pre_occupancy", occupancy, 2);
        check_val("mr_pre_rf_req", bus_if.rf_req, 1);
        reset = 1'b1;
        @(negedge clk);
        check_val("mr_rf_req", bus_if.rf_req, 0);
        check_val("mr_ack", bus_if.ack, 0);
        check_val("mr_occupancy", occupancy, 0);
        check_val("mr_retired", retired_count, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        single_write(16'd1);

        // Randomized traffic with a randomly timed RF.
        rf_auto   = 1'b1;
        log_start = log_addr.size();
        nrand     = 150;
        for (int i = 0; i < nrand; i++) begin
            d = 16'($urandom);
            a = 4'($urandom);
            w = 1'($urandom);
            if (w) begin
                exp_addr.push_back(a);
                exp_data.push_back(d);
            end
            alu_send(d, a, w);
            repeat ($urandom % 3) @(negedge clk);
        end
        wait_drained("rnd_drained");
        repeat (8) @(negedge clk);
        rf_auto = 1'b0;
        check_val("rnd_log_count", log_addr.size() - log_start, exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            if (log_start + i < log_addr.size()) begin
                check_val("rnd_rf_addr", log_addr[log_start+i], exp_addr[i]);
                check_val("rnd_rf_data", log_data[log_start+i], exp_data[i]);
            end
        end
        check_val("rnd_retired", retired_count, 16'(1 + nrand));
        repeat (8) @(negedge clk);

        // 6. Counter wrap: preload near the top, then retire twice.
        @(posedge clk);
        #1;
        force dut.retired_count_q = 16'hFFFE;
        m_retired = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.retired_count_q;
        alu_send(16'h0055, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        check_val("wrap_ffff", retired_count, 16'hFFFF);
        alu_send(16'h0066, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        check_val("wrap_zero", retired_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation still running at t=%0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
